// File: rtl/vs_mvp_transform_pkg.sv
// Shared constants and FSM encoding for the vs_mvp_transform matrix-vector sequencer.
package vs_mvp_transform_pkg;

    localparam int unsigned SHADER_ALU_DATA_WIDTH  = 32;
    localparam int unsigned SHADER_CORE_DATA_WIDTH = 32;
    localparam int unsigned SHADER_ALU_OP_WIDTH    = 4;
    localparam int unsigned VEC_LANES              = 4;

    localparam logic [SHADER_ALU_OP_WIDTH-1:0] OP_DP4 = 4'h6;

    typedef enum logic [1:0] {
        VS_MVP_IDLE  = 2'd0,
        VS_MVP_ISSUE = 2'd1,
        VS_MVP_WAIT  = 2'd2,
        VS_MVP_OUT   = 2'd3
    } vs_mvp_state_e;

endpackage

// File: rtl/vs_mvp_transform_if.sv
// Vertex-in / matrix-write / shader_core / vertex-out signal bundle of vs_mvp_transform.
interface vs_mvp_transform_if #(
    parameter int unsigned DATA_W = 32
);
    import vs_mvp_transform_pkg::*;

    logic                           iVertex_Valid;
    logic [4*DATA_W-1:0]            iVertex;
    logic                           oVertex_Ready;
    logic                           iMat_We;
    logic [1:0]                     iMat_Row;
    logic [4*DATA_W-1:0]            iMat_Data;
    logic                           oMat_Ready;
    logic                           oCore_Valid;
    logic [4*DATA_W-1:0]            oCore_A;
    logic [4*DATA_W-1:0]            oCore_B;
    logic [SHADER_ALU_OP_WIDTH-1:0] oCore_Op;
    logic                           iCore_Ready;
    logic [DATA_W-1:0]              iCore_Result;
    logic                           iCore_Overflow;
    logic                           oValid;
    logic [4*DATA_W-1:0]            oResult;
    logic                           oOverflow;
    logic                           iReady;
    logic                           oTimeout;

    modport slave (
        input  iVertex_Valid, iVertex, iMat_We, iMat_Row, iMat_Data,
               iCore_Ready, iCore_Result, iCore_Overflow, iReady,
        output oVertex_Ready, oMat_Ready, oCore_Valid, oCore_A, oCore_B, oCore_Op,
               oValid, oResult, oOverflow, oTimeout
    );

    modport master (
        output iVertex_Valid, iVertex, iMat_We, iMat_Row, iMat_Data,
               iCore_Ready, iCore_Result, iCore_Overflow, iReady,
        input  oVertex_Ready, oMat_Ready, oCore_Valid, oCore_A, oCore_B, oCore_Op,
               oValid, oResult, oOverflow, oTimeout
    );

endinterface

// File: rtl/vs_mat4_regfile.sv
// Four-row matrix store: one synchronous write port, one combinational read port.
module vs_mat4_regfile #(
    parameter int unsigned ROW_W = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       waddr,
    input  logic [ROW_W-1:0] wdata,
    input  logic [1:0]       raddr,
    output logic [ROW_W-1:0] rdata_c
);

    logic [3:0][ROW_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/vs_mvp_transform.sv
// Matrix-vector transform sequencer: issues one DP4 per matrix row to shader_core and packs
// the four scalar results into a vec4. Optional result watchdog: define VS_MVP_WATCHDOG_EN.
module vs_mvp_transform
    import vs_mvp_transform_pkg::*;
#(
    parameter int unsigned DATA_W  = SHADER_ALU_DATA_WIDTH,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset,
    vs_mvp_transform_if.slave bus
);

    localparam int unsigned VEC_W = VEC_LANES * DATA_W;

    typedef logic [VEC_LANES-1:0][DATA_W-1:0] vec4_t;

    vs_mvp_state_e state_q, state_d;
    logic [1:0]    row_q, row_d;
    vec4_t         core_a_q, core_a_d;
    vec4_t         core_b_q, core_b_d;
    vec4_t         result_q, result_d;
    logic          core_valid_q, core_valid_d;
    logic          vtx_ready_q, vtx_ready_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;

    logic              accept_c;
    logic              mat_we_c;
    logic [VEC_W-1:0]  mat_rd_c;
    logic              res_take_c;
    logic [DATA_W-1:0] res_data_c;
    logic              res_ovf_c;

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("vs_mvp_transform: TIMEOUT must be at least 2");
    end

    assign accept_c = (state_q == VS_MVP_IDLE) && bus.iVertex_Valid;
    assign mat_we_c = (state_q == VS_MVP_IDLE) && bus.iMat_We;

    vs_mat4_regfile #(
        .ROW_W (VEC_W)
    ) u_mat (
        .clk     (clk),
        .reset   (reset),
        .we      (mat_we_c),
        .waddr   (bus.iMat_Row),
        .wdata   (bus.iMat_Data),
        .raddr   (row_d),
        .rdata_c (mat_rd_c)
    );

`ifdef VS_MVP_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            wd_fire_c;

    assign wd_fire_c = (state_q == VS_MVP_WAIT) && !bus.iCore_Ready &&
                       (wd_cnt_q == WD_W'(TIMEOUT - 1));

    // Counts WAIT cycles for the current row; a missing result is replaced by zero.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_q == VS_MVP_ISSUE)     wd_cnt_d = '0;
        else if (state_q == VS_MVP_WAIT) wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (accept_c)       timeout_d = 1'b0;
        else if (wd_fire_c) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign res_take_c   = bus.iCore_Ready | wd_fire_c;
    assign res_data_c   = bus.iCore_Ready ? bus.iCore_Result : '0;
    assign bus.oTimeout = timeout_q;
`else
    assign res_take_c   = bus.iCore_Ready;
    assign res_data_c   = bus.iCore_Result;
    assign bus.oTimeout = 1'b0;
`endif

    assign res_ovf_c = bus.iCore_Ready & bus.iCore_Overflow;

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        core_a_d = core_a_q;
        core_b_d = core_b_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            VS_MVP_IDLE: begin
                if (bus.iVertex_Valid) begin
                    core_a_d = vec4_t'(bus.iVertex);
                    row_d    = 2'd0;
                    ovf_d    = 1'b0;
                    state_d  = VS_MVP_ISSUE;
                end
            end
            VS_MVP_ISSUE: state_d = VS_MVP_WAIT;
            VS_MVP_WAIT: begin
                if (res_take_c) begin
                    result_d[row_q] = res_data_c;
                    ovf_d           = ovf_q | res_ovf_c;
                    if (row_q == 2'd3) begin
                        state_d = VS_MVP_OUT;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = VS_MVP_ISSUE;
                    end
                end
            end
            VS_MVP_OUT: begin
                if (bus.iReady) state_d = VS_MVP_IDLE;
            end
            default: state_d = VS_MVP_IDLE;
        endcase

        // A row written in the accepting cycle is forwarded so the vertex sees the new row.
        if (state_d == VS_MVP_ISSUE) begin
            core_b_d = (mat_we_c && (bus.iMat_Row == row_d)) ? vec4_t'(bus.iMat_Data)
                                                             : vec4_t'(mat_rd_c);
        end

        core_valid_d = (state_d == VS_MVP_ISSUE);
        vtx_ready_d  = (state_d == VS_MVP_IDLE);
        valid_d      = (state_d == VS_MVP_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= VS_MVP_IDLE;
            row_q        <= 2'd0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            result_q     <= '0;
            core_valid_q <= 1'b0;
            vtx_ready_q  <= 1'b1;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            result_q     <= result_d;
            core_valid_q <= core_valid_d;
            vtx_ready_q  <= vtx_ready_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.oVertex_Ready = vtx_ready_q;
    assign bus.oMat_Ready    = vtx_ready_q;
    assign bus.oCore_Valid   = core_valid_q;
    assign bus.oCore_A       = core_a_q;
    assign bus.oCore_B       = core_b_q;
    assign bus.oCore_Op      = OP_DP4;
    assign bus.oValid        = valid_q;
    assign bus.oResult       = result_q;
    assign bus.oOverflow     = ovf_q;

endmodule

// File: tb/tb_vs_mvp_transform.sv
// Self-checking bench for vs_mvp_transform with a behavioural DP4 shader_core of latency 3.
module tb_vs_mvp_transform;
    import vs_mvp_transform_pkg::*;

    localparam int CORE_L     = 3;
    localparam int TB_TIMEOUT = 8;
    localparam int LAT_NOM    = 4 * (1 + CORE_L) + 1;

    typedef logic [3:0][31:0] vec_t;
    typedef vec_t [3:0]       mat_t;
    typedef struct {
        mat_t       rows;
        vec_t       vtx;
        logic [3:0] ovf_mask;
        vec_t       exp_res;
        logic       exp_ovf;
    } tv_t;

    logic clk;
    logic reset;
    vs_mvp_transform_if #(.DATA_W(32)) bus ();

    vs_mvp_transform #(
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    mat_t       model_mat;
    logic [3:0] ovf_mask  = '0;
    logic [3:0] drop_mask = '0;
    bit         spur      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, input logic [31:0] w);
        vec_t v;
        v[0] = x; v[1] = y; v[2] = z; v[3] = w;
        return v;
    endfunction

    function automatic logic [31:0] dp4(input vec_t a, input vec_t b);
        logic [31:0] s = '0;
        for (int i = 0; i < 4; i++) s = s + a[i] * b[i];
        return s;
    endfunction

    // Reference transform: lane r is row r of the resident matrix dotted with the vertex.
    function automatic vec_t model_xform(input vec_t v);
        vec_t r;
        for (int i = 0; i < 4; i++) r[i] = dp4(model_mat[i], v);
        return r;
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // shader_core model: result pulse CORE_L cycles after each issue strobe.
    int          cm_cnt  = 0;
    bit          cm_pend = 0;
    bit          cm_drop = 0;
    logic [31:0] cm_res;
    logic        cm_ovf;
    int          cm_idx  = 0;
    always @(negedge clk) begin
        bus.iCore_Ready    = 1'b0;
        bus.iCore_Overflow = 1'b0;
        bus.iCore_Result   = '0;
        if (reset) begin
            cm_pend = 0;
            cm_idx  = 0;
        end else begin
            if (cm_pend) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    cm_pend = 0;
                    if (!cm_drop) begin
                        bus.iCore_Ready    = 1'b1;
                        bus.iCore_Result   = cm_res;
                        bus.iCore_Overflow = cm_ovf;
                    end
                end
            end
            if (bus.oCore_Valid) begin
                cm_pend = 1;
                cm_cnt  = CORE_L;
                cm_res  = dp4(bus.oCore_A, bus.oCore_B);
                cm_ovf  = ovf_mask[cm_idx];
                cm_drop = drop_mask[cm_idx];
                cm_idx  = (cm_idx + 1) % 4;
            end
            if (spur) begin
                bus.iCore_Ready    = 1'b1;
                bus.iCore_Result   = 32'hDEAD_BEEF;
                bus.iCore_Overflow = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [1:0] r, input vec_t d);
        chk("mat_ready", bus.oMat_Ready, 1'b1);
        bus.iMat_We = 1'b1; bus.iMat_Row = r; bus.iMat_Data = d;
        tick();
        bus.iMat_We = 1'b0;
        model_mat[r] = d;
    endtask

    // Accepts a vertex (optionally with a same-cycle row write) and waits for oValid.
    task automatic run_vertex(input vec_t v, input bit wr, input logic [1:0] wr_r,
                              input vec_t wr_d, output int lat);
        chk("accept_ready", bus.oVertex_Ready, 1'b1);
        bus.iVertex_Valid = 1'b1;
        bus.iVertex       = v;
        if (wr) begin
            bus.iMat_We = 1'b1; bus.iMat_Row = wr_r; bus.iMat_Data = wr_d;
            model_mat[wr_r] = wr_d;
        end
        tick();
        bus.iVertex_Valid = 1'b0;
        bus.iMat_We       = 1'b0;
        lat = 1;
        while (!bus.oValid && lat < 300) begin
            tick();
            lat++;
        end
        if (!bus.oValid) begin
            checks++;
            errors++;
            $display("FAIL vertex_wait: no oValid within %0d cycles", lat);
        end
    endtask

    task automatic drain();
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
        chk("drain_valid", bus.oValid, 1'b0);
        chk("drain_vtx_ready", bus.oVertex_Ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv_t  tbl[5];
        int   lat;
        vec_t exp_v;
        vec_t zero_v;
        int   seen;

        zero_v = '0;
        tbl[0].rows = {mk(0,0,0,1), mk(0,0,1,0), mk(0,1,0,0), mk(1,0,0,0)};
        tbl[0].vtx = mk(1,2,3,4); tbl[0].ovf_mask = 4'b0000;
        tbl[0].exp_res = mk(1,2,3,4); tbl[0].exp_ovf = 1'b0;
        tbl[1].rows = {mk(0,0,0,0), mk(0,0,3,0), mk(2,0,0,0), mk(1,1,1,1)};
        tbl[1].vtx = mk(1,2,3,4); tbl[1].ovf_mask = 4'b0000;
        tbl[1].exp_res = mk(10,2,9,0); tbl[1].exp_ovf = 1'b0;
        tbl[2] = tbl[1]; tbl[2].ovf_mask = 4'b0100; tbl[2].exp_ovf = 1'b1;
        tbl[3] = tbl[1];
        tbl[4].rows = {mk(0,0,0,5), mk(0,0,4,0), mk(0,3,0,0), mk(2,0,0,0)};
        tbl[4].vtx = mk(1,2,3,32'hFFFF_FFFF); tbl[4].ovf_mask = 4'b0000;
        tbl[4].exp_res = mk(2,6,12,32'hFFFF_FFFB); tbl[4].exp_ovf = 1'b0;

        reset = 1'b1;
        bus.iVertex_Valid = 1'b0; bus.iVertex = '0;
        bus.iMat_We = 1'b0; bus.iMat_Row = '0; bus.iMat_Data = '0;
        bus.iReady = 1'b0;
        model_mat = '0;
        repeat (3) tick();

        chk("rst_vtx_ready", bus.oVertex_Ready, 1'b1);
        chk("rst_mat_ready", bus.oMat_Ready, 1'b1);
        chk("rst_core_valid", bus.oCore_Valid, 1'b0);
        chk("rst_valid", bus.oValid, 1'b0);
        chk("rst_overflow", bus.oOverflow, 1'b0);
        chk("rst_timeout", bus.oTimeout, 1'b0);
        chk("rst_core_a", bus.oCore_A, '0);
        chk("rst_core_b", bus.oCore_B, '0);
        chk("rst_result", bus.oResult, '0);
        chk("rst_op", bus.oCore_Op, OP_DP4);
        reset = 1'b0;
        tick();

        // Table-driven vectors: identity, mixed rows, overflow on row 2 then clean vertex, wrap.
        for (int t = 0; t < 5; t++) begin
            ovf_mask = tbl[t].ovf_mask;
            for (int r = 0; r < 4; r++) write_row(2'(r), tbl[t].rows[r]);
            run_vertex(tbl[t].vtx, 1'b0, 2'd0, zero_v, lat);
            chk($sformatf("tbl%0d_result", t), bus.oResult, tbl[t].exp_res);
            chk($sformatf("tbl%0d_overflow", t), bus.oOverflow, tbl[t].exp_ovf);
            chk($sformatf("tbl%0d_latency", t), 128'(lat), 128'(LAT_NOM));
            chk($sformatf("tbl%0d_vtx_ready", t), bus.oVertex_Ready, 1'b0);
            chk($sformatf("tbl%0d_timeout", t), bus.oTimeout, 1'b0);
            drain();
        end
        ovf_mask = '0;

        // OUT stall: output held, no vertex ready, matrix write and stray core pulse ignored.
        for (int r = 0; r < 4; r++) write_row(2'(r), tbl[1].rows[r]);
        run_vertex(mk(1,2,3,4), 1'b0, 2'd0, zero_v, lat);
        exp_v = mk(10,2,9,0);
        for (int i = 0; i < 5; i++) begin
            bus.iMat_We = 1'b1; bus.iMat_Row = 2'd0; bus.iMat_Data = mk(77,77,77,77);
            spur = (i == 1);
            tick();
            chk($sformatf("stall%0d_valid", i), bus.oValid, 1'b1);
            chk($sformatf("stall%0d_result", i), bus.oResult, exp_v);
            chk($sformatf("stall%0d_vtx_ready", i), bus.oVertex_Ready, 1'b0);
            chk($sformatf("stall%0d_overflow", i), bus.oOverflow, 1'b0);
        end
        bus.iMat_We = 1'b0;
        spur = 0;
        drain();
        run_vertex(mk(1,2,3,4), 1'b0, 2'd0, zero_v, lat);
        chk("stall_write_ignored", bus.oResult, exp_v);
        drain();

        // Row write in the same cycle as the accept is seen by that vertex.
        run_vertex(mk(1,2,3,4), 1'b1, 2'd0, mk(3,3,3,3), lat);
        exp_v = bus.oResult;
        chk("samecyc_lane_x", 128'(exp_v[0]), 128'(30));
        chk("samecyc_result", bus.oResult, model_xform(mk(1,2,3,4)));
        drain();

        // Randomized vertices against the reference transform.
        for (int it = 0; it < 24; it++) begin
            vec_t v;
            int   nwr;
            bit   wr;
            logic [1:0] wr_r;
            vec_t wr_d;
            nwr = $urandom_range(0, 3);
            for (int k = 0; k < nwr; k++)
                write_row(2'($urandom_range(0, 3)),
                          mk($urandom, $urandom_range(0, 9), $urandom, $urandom_range(0, 9)));
            v        = mk($urandom, $urandom, $urandom_range(0, 100), $urandom);
            wr       = ($urandom_range(0, 3) == 0);
            wr_r     = 2'($urandom_range(0, 3));
            wr_d     = mk($urandom, $urandom, $urandom, $urandom);
            ovf_mask = 4'($urandom_range(0, 15));
            run_vertex(v, wr, wr_r, wr_d, lat);
            chk($sformatf("rnd%0d_result", it), bus.oResult, model_xform(v));
            chk($sformatf("rnd%0d_overflow", it), bus.oOverflow, |ovf_mask);
            chk($sformatf("rnd%0d_latency", it), 128'(lat), 128'(LAT_NOM));
            repeat ($urandom_range(0, 3)) tick();
            chk($sformatf("rnd%0d_hold", it), bus.oResult, model_xform(v));
            drain();
        end
        ovf_mask = '0;

        // Reset during WAIT of row 1 aborts the vertex and clears the matrix.
        bus.iVertex_Valid = 1'b1; bus.iVertex = mk(1,2,3,4);
        tick();
        bus.iVertex_Valid = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("midrst_vtx_ready", bus.oVertex_Ready, 1'b1);
        chk("midrst_mat_ready", bus.oMat_Ready, 1'b1);
        chk("midrst_core_valid", bus.oCore_Valid, 1'b0);
        chk("midrst_valid", bus.oValid, 1'b0);
        chk("midrst_overflow", bus.oOverflow, 1'b0);
        chk("midrst_result", bus.oResult, '0);
        chk("midrst_core_a", bus.oCore_A, '0);
        chk("midrst_core_b", bus.oCore_B, '0);
        repeat (2) tick();
        reset = 1'b0;
        model_mat = '0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.oValid) seen++;
        end
        chk("midrst_no_valid", 128'(seen), 128'(0));
        run_vertex(mk(1,2,3,4), 1'b0, 2'd0, zero_v, lat);
        chk("midrst_matrix_cleared", bus.oResult, model_xform(mk(1,2,3,4)));
        drain();

`ifdef VS_MVP_WATCHDOG_EN
        // Dropped row-3 pulse: lane W forced to zero and sticky timeout for this vertex only.
        for (int r = 0; r < 4; r++) write_row(2'(r), tbl[1].rows[r]);
        write_row(2'd3, mk(1,1,1,1));
        drop_mask = 4'b1000;
        run_vertex(mk(1,2,3,4), 1'b0, 2'd0, zero_v, lat);
        chk("wd_result", bus.oResult, mk(10,2,9,0));
        chk("wd_timeout", bus.oTimeout, 1'b1);
        chk("wd_latency", 128'(lat), 128'(3 * (1 + CORE_L) + 1 + TB_TIMEOUT + 1));
        drain();
        drop_mask = '0;
        run_vertex(mk(1,2,3,4), 1'b0, 2'd0, zero_v, lat);
        chk("wd_next_result", bus.oResult, mk(10,2,9,10));
        chk("wd_next_timeout", bus.oTimeout, 1'b0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
